// File: rtl/z80_bus_pkg.sv
// Shared Z80 bus definitions: bus widths and the ROM front-end state type.
package z80_bus_pkg;

  localparam int unsigned Z80_ADDR_W = 16;
  localparam int unsigned Z80_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPTURE,
    WAITS,
    HOLD,
    DONE
  } rom_bus_state_t;

endpackage

// File: rtl/rom_bus_ctrl.sv
// Z80 memory-read front end for a synchronous ROM.
// Decodes CPU read cycles inside a 2**ROM_ADDR_W byte window at BASE_ADDR,
// fires a one-cycle ROM read, stretches the CPU cycle with WAIT_n to cover
// the ROM's one-cycle latency plus WAIT_STATES extra cycles, then presents
// the captured byte with an output enable until the strobes go away.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   cpu_addr    CPU address bus
//   cpu_mreq_n  CPU memory request, active low
//   cpu_rd_n    CPU read strobe, active low
//   cpu_wait_n  to CPU WAIT_n, low stretches the cycle
//   cpu_dout    read data toward the CPU data bus
//   cpu_doe     high while cpu_dout should drive the bus
//   rom_ena     ROM read enable, one-cycle pulse
//   rom_addr    registered ROM address
//   rom_dout    ROM read data, valid the cycle after rom_ena
module rom_bus_ctrl
  import z80_bus_pkg::*;
#(
  parameter int unsigned         ROM_ADDR_W  = 14,
  parameter logic [Z80_ADDR_W-1:0] BASE_ADDR = 16'h0000,
  parameter int unsigned         WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [Z80_ADDR_W-1:0] cpu_addr,
  input  logic                  cpu_mreq_n,
  input  logic                  cpu_rd_n,
  output logic                  cpu_wait_n,
  output logic [Z80_DATA_W-1:0] cpu_dout,
  output logic                  cpu_doe,
  output logic                  rom_ena,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [Z80_DATA_W-1:0] rom_dout
);

  if (WAIT_STATES > 7 || ROM_ADDR_W >= 16 || ROM_ADDR_W == 0) begin : g_param_check
    $fatal(1, "rom_bus_ctrl: WAIT_STATES must be 0..7 and ROM_ADDR_W 1..15");
  end

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  rom_bus_state_t state, state_next;
  logic [2:0]     wait_cnt;
  logic           active;
  logic           hit;

  assign active = !cpu_mreq_n && !cpu_rd_n;
  assign hit    = active &&
                  (cpu_addr[Z80_ADDR_W-1:ROM_ADDR_W] == BASE_ADDR[Z80_ADDR_W-1:ROM_ADDR_W]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Address capture, data capture and wait-state counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      cpu_dout <= '0;
      wait_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (hit) rom_addr <= cpu_addr[ROM_ADDR_W-1:0];
        // An aborted cycle leaves the previous byte on cpu_dout.
        CAPTURE: if (active) begin
          cpu_dout <= rom_dout;
          wait_cnt <= WAIT_INIT;
        end
        WAITS: if (active) wait_cnt <= wait_cnt - 3'd1;
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hit) state_next = FETCH;
      FETCH:   state_next = active ? CAPTURE : IDLE;
      CAPTURE: if (!active)            state_next = IDLE;
               else if (WAIT_STATES > 0) state_next = WAITS;
               else                    state_next = HOLD;
      WAITS:   if (!active)             state_next = IDLE;
               else if (wait_cnt == 3'd1) state_next = HOLD;
      HOLD:    if (!active) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; wait is qualified with rst_n so a hit seen while reset is
  // asserted cannot hold the CPU.
  always_comb begin
    rom_ena    = 1'b0;
    cpu_doe    = 1'b0;
    cpu_wait_n = 1'b1;
    case (state)
      IDLE:                  if (hit && rst_n) cpu_wait_n = 1'b0;
      FETCH: begin
        rom_ena    = 1'b1;
        cpu_wait_n = 1'b0;
      end
      CAPTURE, WAITS:        cpu_wait_n = 1'b0;
      HOLD:                  cpu_doe = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rom_bus_ctrl.sv
module tb_rom_bus_ctrl;
  import z80_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        mreq_n, rd_n;
  logic        wait_n [3];
  logic        doe    [3];
  logic        ena    [3];
  logic [7:0]  dout   [3];
  logic [7:0]  rdout  [3];
  logic [13:0] raddr  [3];

  logic [7:0]  mem [16384];
  logic [7:0]  exp_d [3];
  int          cnt_low [3];
  int          cnt_doe [3];
  int          cnt_ena [3];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  rom_bus_ctrl #(.ROM_ADDR_W(14), .BASE_ADDR(16'h0000), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_mreq_n(mreq_n), .cpu_rd_n(rd_n),
    .cpu_wait_n(wait_n[0]), .cpu_dout(dout[0]), .cpu_doe(doe[0]),
    .rom_ena(ena[0]), .rom_addr(raddr[0]), .rom_dout(rdout[0]));
  rom_bus_ctrl #(.ROM_ADDR_W(14), .BASE_ADDR(16'h0000), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_mreq_n(mreq_n), .cpu_rd_n(rd_n),
    .cpu_wait_n(wait_n[1]), .cpu_dout(dout[1]), .cpu_doe(doe[1]),
    .rom_ena(ena[1]), .rom_addr(raddr[1]), .rom_dout(rdout[1]));
  rom_bus_ctrl #(.ROM_ADDR_W(14), .BASE_ADDR(16'h0000), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_mreq_n(mreq_n), .cpu_rd_n(rd_n),
    .cpu_wait_n(wait_n[2]), .cpu_dout(dout[2]), .cpu_doe(doe[2]),
    .rom_ena(ena[2]), .rom_addr(raddr[2]), .rom_dout(rdout[2]));

  // Synchronous ROM models: data one cycle after enable, junk otherwise.
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      rdout[i] <= ena[i] ? mem[raddr[i]] : 8'($urandom);

  function automatic int wv(input int i);
    return (i == 0) ? 0 : (i == 1) ? 2 : 3;
  endfunction

  function automatic logic is_hit(input logic [15:0] a, input logic m, input logic r);
    return !m && !r && (a[15:14] == 2'b00);
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic m, input logic r);
    cpu_addr = a;
    mreq_n   = m;
    rd_n     = r;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobes held for cycles 0..L-1, then released for three cycles.
  task automatic run_counted(input logic [15:0] a, input logic m, input logic r, input int L);
    for (int i = 0; i < 3; i++) begin
      cnt_low[i] = 0; cnt_doe[i] = 0; cnt_ena[i] = 0;
    end
    for (int c = 0; c <= L + 2; c++) begin
      if (c < L) drive(a, m, r); else drive(a, 1'b1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        cnt_low[i] += int'(!wait_n[i]);
        cnt_doe[i] += int'(doe[i]);
        cnt_ena[i] += int'(ena[i]);
      end
      step();
    end
    if (is_hit(a, m, r) && L >= 3)
      for (int i = 0; i < 3; i++) exp_d[i] = mem[a[13:0]];
  endtask

  // Per-cycle reference: wait low from the hit until HOLD or until one cycle
  // past the strobe drop; doe from cycle 3+W to the drop cycle; byte visible
  // from cycle 3 provided the strobes were still present at cycle 2.
  task automatic check_txn(input logic [15:0] a, input logic m, input logic r, input int L);
    logic h;
    int   w, lim;
    logic elow, edoe, eena;
    h = is_hit(a, m, r);
    for (int c = 0; c <= L + 2; c++) begin
      if (c == 0)     drive(a, m, r);
      else if (c < L) drive(h ? 16'($urandom) : a, m, r);
      else            drive(16'($urandom), 1'b1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        w = wv(i);
        if (h && c == 3 && L >= 3) exp_d[i] = mem[a[13:0]];
        lim  = (L + 1 < 3 + w) ? L + 1 : 3 + w;
        elow = h && (c < lim);
        edoe = h && (c >= 3 + w) && (c <= L);
        eena = h && (c == 1);
        chk("wait_n", i, 32'(wait_n[i]), 32'(!elow));
        chk("doe", i, 32'(doe[i]), 32'(edoe));
        chk("rom_ena", i, 32'(ena[i]), 32'(eena));
        chk("dout", i, 32'(dout[i]), 32'(exp_d[i]));
        if (eena) chk("rom_addr", i, 32'(raddr[i]), 32'(a[13:0]));
      end
      step();
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        mreq_n;
    logic        rd_n;
    int          len;
    int          low0, low2, low3;
    int          doe0, doe2, doe3;
    int          ena;
    logic [7:0]  dout0;
  } vec_t;

  vec_t vecs [8];

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = a[7:0] ^ {2'b00, a[13:8]};
    mem[14'h0123] = 8'hA5;

    vecs[0] = '{16'h0123, 1'b0, 1'b0, 8, 3, 5, 6, 6, 4, 3, 1, 8'hA5};
    vecs[1] = '{16'h4000, 1'b0, 1'b0, 8, 0, 0, 0, 0, 0, 0, 0, 8'hA5};
    vecs[2] = '{16'h0010, 1'b0, 1'b1, 8, 0, 0, 0, 0, 0, 0, 0, 8'hA5};
    vecs[3] = '{16'h0010, 1'b1, 1'b0, 8, 0, 0, 0, 0, 0, 0, 0, 8'hA5};
    vecs[4] = '{16'h3FFF, 1'b0, 1'b0, 2, 3, 3, 3, 0, 0, 0, 1, 8'hA5};
    vecs[5] = '{16'h1000, 1'b0, 1'b0, 4, 3, 5, 5, 2, 0, 0, 1, 8'h10};
    vecs[6] = '{16'hC123, 1'b0, 1'b0, 5, 0, 0, 0, 0, 0, 0, 0, 8'h10};
    vecs[7] = '{16'h2ABC, 1'b0, 1'b0, 1, 2, 2, 2, 0, 0, 0, 1, 8'h10};

    // Reset with an in-window read already on the bus
    rst_n = 1'b0;
    drive(16'h0123, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_wait_n", i, 32'(wait_n[i]), 32'd1);
      chk("rst_doe", i, 32'(doe[i]), 32'd0);
      chk("rst_dout", i, 32'(dout[i]), 32'd0);
      chk("rst_ena", i, 32'(ena[i]), 32'd0);
      chk("rst_addr", i, 32'(raddr[i]), 32'd0);
      exp_d[i] = 8'h00;
    end
    drive(16'h0000, 1'b1, 1'b1);
    rst_n = 1'b1;
    step();

    // Table-driven transactions
    for (int v = 0; v < 8; v++) begin
      run_counted(vecs[v].addr, vecs[v].mreq_n, vecs[v].rd_n, vecs[v].len);
      chk("tbl_low", 0, 32'(cnt_low[0]), 32'(vecs[v].low0));
      chk("tbl_low", 1, 32'(cnt_low[1]), 32'(vecs[v].low2));
      chk("tbl_low", 2, 32'(cnt_low[2]), 32'(vecs[v].low3));
      chk("tbl_doe", 0, 32'(cnt_doe[0]), 32'(vecs[v].doe0));
      chk("tbl_doe", 1, 32'(cnt_doe[1]), 32'(vecs[v].doe2));
      chk("tbl_doe", 2, 32'(cnt_doe[2]), 32'(vecs[v].doe3));
      for (int i = 0; i < 3; i++) chk("tbl_ena", i, 32'(cnt_ena[i]), 32'(vecs[v].ena));
      chk("tbl_dout", 0, 32'(dout[0]), 32'(vecs[v].dout0));
    end

    // Read 0x0123 cycle by cycle, then reset while WAIT_STATES=2 sits in HOLD
    for (int c = 0; c <= 6; c++) begin
      drive(16'h0123, 1'b0, 1'b0);
      @(negedge clk);
      if (c <= 2) chk("a_wait_lo", 0, 32'(wait_n[0]), 32'd0);
      chk("a_ena", 0, 32'(ena[0]), 32'(c == 1));
      if (c == 1) chk("a_addr", 0, 32'(raddr[0]), 32'h0123);
      if (c == 3) begin
        chk("a_wait_hi", 0, 32'(wait_n[0]), 32'd1);
        chk("a_doe", 0, 32'(doe[0]), 32'd1);
        chk("a_dout", 0, 32'(dout[0]), 32'hA5);
      end
      if (c <= 5) chk("a_wait_lo", 2, 32'(wait_n[2]), 32'd0);
      if (c == 5) chk("a_doe", 1, 32'(doe[1]), 32'd1);
      if (c == 6) begin
        chk("a_wait_hi", 2, 32'(wait_n[2]), 32'd1);
        chk("a_doe", 2, 32'(doe[2]), 32'd1);
        chk("a_dout", 2, 32'(dout[2]), 32'hA5);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_wait_n", 1, 32'(wait_n[1]), 32'd1);
        chk("mid_rst_doe", 1, 32'(doe[1]), 32'd0);
        chk("mid_rst_dout", 1, 32'(dout[1]), 32'd0);
        chk("mid_rst_ena", 1, 32'(ena[1]), 32'd0);
        chk("mid_rst_state", 1, 32'(u_w2.state), 32'(IDLE));
        chk("mid_rst_wait_n", 0, 32'(wait_n[0]), 32'd1);
      end
      if (c < 6) step();
    end
    drive(16'h0000, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) exp_d[i] = 8'h00;
    step();

    // rd_n released during CAPTURE, then a normal read
    for (int c = 0; c <= 4; c++) begin
      if (c < 2)       drive(16'h0200, 1'b0, 1'b0);
      else if (c == 2) drive(16'h0200, 1'b0, 1'b1);
      else             drive(16'h0200, 1'b1, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 3; i++) chk("b_doe", i, 32'(doe[i]), 32'd0);
      if (c == 2) chk("b_wait_lo", 0, 32'(wait_n[0]), 32'd0);
      if (c == 3) begin
        chk("b_state", 0, 32'(u_w0.state), 32'(IDLE));
        chk("b_wait_hi", 0, 32'(wait_n[0]), 32'd1);
        chk("b_dout", 0, 32'(dout[0]), 32'd0);
      end
      step();
    end
    check_txn(16'h0201, 1'b0, 1'b0, 7);

    // Back-to-back reads 0x0000 then 0x3FFF with a one-cycle strobe gap
    cnt_ena[0] = 0;
    for (int c = 0; c <= 14; c++) begin
      if (c <= 3)       drive(16'h0000, 1'b0, 1'b0);
      else if (c == 4)  drive(16'h0000, 1'b1, 1'b1);
      else if (c <= 11) drive(16'h3FFF, 1'b0, 1'b0);
      else              drive(16'h3FFF, 1'b1, 1'b1);
      @(negedge clk);
      cnt_ena[0] += int'(ena[0]);
      if (c == 3) chk("c_dout1", 0, 32'(dout[0]), 32'(mem[14'h0000]));
      if (c == 5) begin
        chk("c_state_done", 0, 32'(u_w0.state), 32'(DONE));
        chk("c_done_wait", 0, 32'(wait_n[0]), 32'd1);
        chk("c_done_doe", 0, 32'(doe[0]), 32'd0);
      end
      if (c == 6) chk("c_wait_lo", 0, 32'(wait_n[0]), 32'd0);
      if (c == 7) begin
        chk("c_ena", 0, 32'(ena[0]), 32'd1);
        chk("c_addr", 0, 32'(raddr[0]), 32'h3FFF);
      end
      if (c == 9) begin
        chk("c_doe", 0, 32'(doe[0]), 32'd1);
        chk("c_dout2", 0, 32'(dout[0]), 32'(mem[14'h3FFF]));
      end
      step();
    end
    chk("c_ena_count", 0, 32'(cnt_ena[0]), 32'd2);
    for (int i = 0; i < 3; i++) begin
      exp_d[i] = mem[14'h3FFF];
      chk("c_dout_final", i, 32'(dout[i]), 32'(exp_d[i]));
    end

    // Randomized transactions against the reference model
    for (int t = 0; t < 80; t++) begin
      int          k, L;
      logic [15:0] a;
      logic        m, r;
      k = int'($urandom_range(0, 5));
      L = int'($urandom_range(1, 10));
      m = 1'b0;
      r = 1'b0;
      case (k)
        0, 1, 2: a = {2'b00, 14'($urandom)};
        3:       a = {2'($urandom_range(1, 3)), 14'($urandom)};
        4: begin a = 16'($urandom); r = 1'b1; end
        default: begin a = 16'($urandom); m = 1'b1; end
      endcase
      check_txn(a, m, r, L);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
